str_det_arbiter: RTL
====================

STR_DET_ARBITER -- requirements
Module: str_det_arbiter

Interface
REQ-001 Parameter CNT_W, default 8, width of per-requester match counters.
REQ-002 Parameter TIMEOUT_CYC, default 16, idle-cycle limit for the timeout feature (REQ-027).
REQ-003 Port clk_in  input  1  single clock, rising edge.
REQ-004 Port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 Port req0_valid / req1_valid  input  1  requester byte valid.
REQ-006 Port req0_data / req1_data  input  8  requester byte (ASCII).
REQ-007 Port req0_last / req1_last  input  1  byte is last of frame.
REQ-008 Port req0_ready / req1_ready  output  1  byte accepted when valid&&ready.
REQ-009 Port det_out  output  1  one-cycle pulse, "Hello" detected.
REQ-010 Port det_src  output  1  requester index of the detection; valid while det_out=1.
REQ-011 Port cnt0 / cnt1  output  CNT_W  saturating per-requester match count.
REQ-012 Port busy  output  1  high while a frame is granted (states SERVE, FLUSH).

Function
REQ-013 Arbiter FSM SHALL have states IDLE, SERVE, FLUSH; encoding one-hot; unreachable codes SHALL return to IDLE.
REQ-014 IDLE: one valid requester -> grant it; both valid -> grant the one not served last (round-robin pointer); neither -> stay IDLE.
REQ-015 IDLE->SERVE takes one cycle; granted ready SHALL assert in the first SERVE cycle; non-granted ready SHALL stay 0 in all states.
REQ-016 SERVE: each accepted byte SHALL be fed to the matcher in the same cycle; grant SHALL be held for the whole frame regardless of the other requester.
REQ-017 SERVE: accepted byte with last=1 -> FLUSH; round-robin pointer updated to the granted index.
REQ-018 FLUSH: ready 0, matcher cleared to check_H, one cycle, then IDLE.
REQ-019 Matcher SHALL detect consecutive accepted bytes "H","e","l","l","o"; valid=0 cycles SHALL NOT break a match.
REQ-020 On mismatch matcher SHALL return to check_H and re-evaluate the current byte, so "HHello" is detected.
REQ-021 det_out SHALL pulse exactly one cycle, registered, the cycle after the "o" byte is accepted; det_src = granted index.
REQ-022 A match whose "o" carries last=1 SHALL still be reported.
REQ-023 cnt0/cnt1 SHALL increment by 1 in the det_out cycle for det_src, saturating at 2^CNT_W-1.
REQ-024 Overlapping matches SHALL NOT occur ("Hello" has no self-overlap); "HelloHello" SHALL give two pulses.

Reset
REQ-025 rst_n_in low SHALL asynchronously force: state IDLE, matcher check_H, pointer to requester 1 (so requester 0 wins first tie), ready 0, det_out 0, det_src 0, cnt0/cnt1 0, busy 0.
REQ-026 Reset asserted mid-frame SHALL discard partial match and grant; no det_out pulse on release.

Configuration
REQ-027 Macro STR_DET_TIMEOUT_EN defined: SERVE SHALL count consecutive cycles with no accepted byte; on reaching TIMEOUT_CYC -> FLUSH, port tmo_out (output 1) pulses one cycle, pointer updated as for last; counter clears on any accepted byte.
REQ-028 Macro undefined: no timeout logic, no tmo_out port; a granted frame is held indefinitely.

Structure
REQ-029 Shared package str_det_pkg SHALL hold the arbiter state encodings, matcher state encodings and the pattern byte constants.
REQ-030 Matcher SHALL be a sub-module str_match_fsm (inputs: byte, byte_en, clear; output: hit pulse); arbiter and counters stay in str_det_arbiter.

Verification
REQ-031 Reset, req0 sends "Hello" last on "o" -> ready0 high from 2nd cycle, det_out=1 det_src=0 one cycle after "o", cnt0=1, FLUSH then IDLE.
REQ-032 Both valid from reset, each sends 3-byte frame -> req0 served first, then req1; req1_ready=0 throughout req0 frame.
REQ-033 req1 sends "HHelxHello" with valid gaps -> exactly one det_out, det_src=1, cnt1=1.
REQ-034 CNT_W=2, req0 sends "Hello" x5 -> cnt0 = 1,2,3,3,3.
REQ-035 rst_n_in low after "Hell" accepted, then release and send "o" -> no det_out, cnt0=0.
REQ-036 STR_DET_TIMEOUT_EN, TIMEOUT_CYC=16, req0 sends "He" then stops -> tmo_out after 16 idle cycles, busy drops, pending req1 granted next.

Source files
------------

// File: rtl/str_det_pkg.sv
// -----------------------------------------------------------------------------
// str_det_pkg
// Shared definitions for the "Hello" detector arbiter:
//   - arb_state_e   : one-hot arbiter states (IDLE / SERVE / FLUSH)
//   - match_state_e : matcher progress through the pattern "Hello"
//   - CH_*          : pattern byte constants (ASCII)
//   - match_restart : where the matcher lands when a byte breaks a partial match
// -----------------------------------------------------------------------------
package str_det_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'b001,
    ARB_SERVE = 3'b010,
    ARB_FLUSH = 3'b100
  } arb_state_e;

  typedef enum logic [2:0] {
    M_CHECK_H  = 3'd0,
    M_CHECK_E  = 3'd1,
    M_CHECK_L1 = 3'd2,
    M_CHECK_L2 = 3'd3,
    M_CHECK_O  = 3'd4
  } match_state_e;

  localparam logic [7:0] CH_H = 8'h48;  // 'H'
  localparam logic [7:0] CH_E = 8'h65;  // 'e'
  localparam logic [7:0] CH_L = 8'h6C;  // 'l'
  localparam logic [7:0] CH_O = 8'h6F;  // 'o'

  // "Hello" has no proper prefix that is also a suffix, so a broken match only
  // needs to re-test the current byte as a possible new 'H'.
  function automatic match_state_e match_restart(input logic [7:0] b);
    return (b == CH_H) ? M_CHECK_E : M_CHECK_H;
  endfunction

endpackage

// File: rtl/str_match_fsm.sv
// -----------------------------------------------------------------------------
// str_match_fsm
// Detects the byte sequence "Hello" in a stream of enabled bytes.
// Cycles with byte_en=0 leave the progress untouched.
// Ports:
//   clk_in, rst_n_in : clock (rising edge), asynchronous active-low reset
//   byte_in          : candidate byte
//   byte_en          : byte_in is part of the stream this cycle
//   clear            : abandon any partial match (priority over byte_en)
//   hit              : combinational, high in the cycle the closing 'o' is fed
//   state_dbg        : current matcher state, for observation
// -----------------------------------------------------------------------------
module str_match_fsm
  import str_det_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] byte_in,
  input  logic       byte_en,
  input  logic       clear,
  output logic       hit,
  output logic [2:0] state_dbg
);

  match_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (clear) begin
      state_d = M_CHECK_H;
    end else if (byte_en) begin
      case (state_q)
        M_CHECK_H:  state_d = match_restart(byte_in);
        M_CHECK_E:  state_d = (byte_in == CH_E) ? M_CHECK_L1 : match_restart(byte_in);
        M_CHECK_L1: state_d = (byte_in == CH_L) ? M_CHECK_L2 : match_restart(byte_in);
        M_CHECK_L2: state_d = (byte_in == CH_L) ? M_CHECK_O  : match_restart(byte_in);
        M_CHECK_O: begin
          if (byte_in == CH_O) begin
            hit     = 1'b1;
            state_d = M_CHECK_H;
          end else begin
            state_d = match_restart(byte_in);
          end
        end
        default:    state_d = M_CHECK_H;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= M_CHECK_H;
    else           state_q <= state_d;
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/str_det_arbiter.sv
// -----------------------------------------------------------------------------
// str_det_arbiter
// Two requesters stream ASCII frames; a round-robin arbiter grants one frame at
// a time to a shared "Hello" matcher and counts detections per requester.
// Optional macro STR_DET_TIMEOUT_EN: abandons a granted frame after
// TIMEOUT_CYC consecutive cycles without an accepted byte (adds tmo_out).
//
// Handshake: a byte on reqN_* transfers at a rising edge where reqN_valid and
// reqN_ready are both high; ready never depends on valid, and a requester holds
// valid/data/last stable until the transfer happens.
//
// Ports:
//   clk_in, rst_n_in        : clock, asynchronous active-low reset
//   reqN_valid/data/last    : requester byte stream (N = 0,1)
//   reqN_ready              : high only for the granted requester while serving
//   det_out / det_src       : one-cycle detection pulse and its requester
//   cnt0 / cnt1             : saturating detection counters
//   busy                    : a frame is granted (SERVE or FLUSH)
//   tmo_out                 : timeout pulse (only with STR_DET_TIMEOUT_EN)
//   dbg_arb_state           : arbiter state, for observation
//   dbg_match_state         : matcher state, for observation
// -----------------------------------------------------------------------------
module str_det_arbiter
  import str_det_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             det_out,
  output logic             det_src,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy,
`ifdef STR_DET_TIMEOUT_EN
  output logic             tmo_out,
`endif
  output logic [2:0]       dbg_arb_state,
  output logic [2:0]       dbg_match_state
);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;    // index of the granted requester
  logic             rr_q, rr_d;          // requester served last
  logic             det_q, det_d;
  logic             det_src_q, det_src_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic       serving, accept, g_valid, g_last, hit, tmo_hit;
  logic [7:0] g_data;

  assign serving = (state_q == ARB_SERVE);
  assign g_valid = grant_q ? req1_valid : req0_valid;
  assign g_data  = grant_q ? req1_data  : req0_data;
  assign g_last  = grant_q ? req1_last  : req0_last;
  assign accept  = serving && g_valid;

  assign req0_ready = serving && !grant_q;
  assign req1_ready = serving &&  grant_q;

  str_match_fsm u_match (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .byte_in   (g_data),
    .byte_en   (accept),
    .clear     (state_q == ARB_FLUSH),
    .hit       (hit),
    .state_dbg (dbg_match_state)
  );

`ifdef STR_DET_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d;

  // Counts idle SERVE cycles; any accepted byte or leaving SERVE clears it.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit   = 1'b0;
    if (serving && !accept) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      tmo_hit   = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    end
    tmo_d = tmo_hit;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tmo_out = tmo_q;
`else
  // No timeout in this build: a granted frame is held until its last byte.
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_d = ~rr_q;
          state_d = ARB_SERVE;
        end else if (req0_valid) begin
          grant_d = 1'b0;
          state_d = ARB_SERVE;
        end else if (req1_valid) begin
          grant_d = 1'b1;
          state_d = ARB_SERVE;
        end
      end
      ARB_SERVE: begin
        if ((accept && g_last) || tmo_hit) begin
          state_d = ARB_FLUSH;
          rr_d    = grant_q;
        end
      end
      ARB_FLUSH: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Counters move on the same edge that raises det_out, so the new count is
  // visible during the pulse.
  always_comb begin
    det_d     = hit;
    det_src_d = hit ? grant_q : det_src_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (hit && !grant_q && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (hit &&  grant_q && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ARB_IDLE;
      grant_q   <= 1'b0;
      rr_q      <= 1'b1;
      det_q     <= 1'b0;
      det_src_q <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      det_q     <= det_d;
      det_src_q <= det_src_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign det_out       = det_q;
  assign det_src       = det_src_q;
  assign cnt0          = cnt0_q;
  assign cnt1          = cnt1_q;
  assign busy          = (state_q == ARB_SERVE) || (state_q == ARB_FLUSH);
  assign dbg_arb_state = state_q;

endmodule
